// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame constants and the parity helper
// used by both the tx and rx paths.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Parity bit value a transmitter would send: XOR of data for even, XNOR for odd.
   function automatic logic par_calc(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_shift_reg.sv
// Receive shift register: right-shifts with the new bit entering the MSB, so an
// LSB-first serial stream is reassembled in place after eight shifts.
module rx_shift_reg (
   input  logic       clock,
   input  logic       reset,
   input  logic       shift_en,
   input  logic       bit_in,
   output logic [7:0] data_out
);

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out <= '0;
      end else if (shift_en) begin
         data_out <= {bit_in, data_out[7:1]};
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled start detection and mid-bit
// sampling of data, optional parity and stop bits; presents one byte per frame.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
   parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sample_tick,
   input  logic       rx_in,
   input  logic       parity_en,
   input  logic       parity_odd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   import uart_pkg::*;

   localparam int unsigned       TICK_W    = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   rx_state_t         state;
   rx_state_t         state_next;
   logic [1:0]        sync_q;
   logic              rx_s;
   logic [TICK_W-1:0] tick_cnt;
   logic [2:0]        bit_cnt;
   logic              par_en_q;
   logic              par_odd_q;
   logic              par_mis;
   logic [7:0]        shift_data;

   logic              tick_clr;
   logic              bit_clr;
   logic              shift_en;
   logic              latch_cfg;
   logic              par_store;
   logic              frame_done;

   // Synchronizer runs every clock, independent of sample_tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[0], rx_in};
      end
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      tick_clr   = 1'b0;
      bit_clr    = 1'b0;
      shift_en   = 1'b0;
      latch_cfg  = 1'b0;
      par_store  = 1'b0;
      frame_done = 1'b0;
      if (sample_tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_next = START;
                  tick_clr   = 1'b1;
                  latch_cfg  = 1'b1;
               end
            end
            START: begin
               if (tick_cnt == TICK_MID) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     tick_clr   = 1'b1;
                     bit_clr    = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
            DATA: begin
               if (tick_cnt == TICK_LAST) begin
                  shift_en = 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     state_next = par_en_q ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (tick_cnt == TICK_LAST) begin
                  par_store  = 1'b1;
                  state_next = STOP;
               end
            end
            STOP: begin
               if (tick_cnt == TICK_LAST) begin
                  frame_done = 1'b1;
                  state_next = rx_s ? IDLE : WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         par_mis    <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (sample_tick) begin
            tick_cnt <= tick_clr ? '0 : tick_cnt + 1'b1;
         end
         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (latch_cfg) begin
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
         end
         // Cleared on entry to DATA so a parity-less frame always reports 0.
         if (bit_clr) begin
            par_mis <= 1'b0;
         end else if (par_store) begin
            par_mis <= rx_s ^ par_calc(shift_data, par_odd_q);
         end
         if (frame_done) begin
            rx_data    <= shift_data;
            rx_valid   <= 1'b1;
            frame_err  <= ~rx_s;
            parity_err <= par_mis;
         end
      end
   end

   assign rx_busy = (state != IDLE);

   rx_shift_reg u_shift (
      .clock    (clock),
      .reset    (reset),
      .shift_en (shift_en),
      .bit_in   (rx_s),
      .data_out (shift_data)
   );

endmodule
